// File: rtl/scurve_pkg.sv
// Shared state encoding and record constants for the S-curve test blocks.
package scurve_pkg;

    localparam int CNT_W = 16;

    localparam logic [3:0] TAG_DAC = 4'h1;
    localparam logic [3:0] TAG_CHN = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WINDOW,
        ST_GAP,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/scurve_trig_edge_sync.sv
// Two-flop synchronizer for an asynchronous trigger plus rising-edge detect.
module trig_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], din};
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/scurve_single_point_test.sv
// One S-curve point: fires CTest pulses, counts one trigger per pulse,
// then writes a 3-word record into the SCurve data FIFO.
module scurve_single_point_test
    import scurve_pkg::*;
#(
    parameter int PULSE_NUM   = 1000,
    parameter int PULSE_WIDTH = 4,
    parameter int TRIG_WINDOW = 16,
    parameter int PULSE_GAP   = 64
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             Single_Test_Start,
    input  logic             Test_Abort,
    input  logic [9:0]       DAC_Code,
    input  logic [5:0]       Test_Chn,
    input  logic             Trigger_In,
    output logic             CTest_Pulse,
    input  logic             SCurve_Data_fifo_full,
    output logic             SCurve_Data_fifo_wr_en,
    output logic [CNT_W-1:0] SCurve_Data_fifo_dout,
    output logic             Single_Test_Done,
    output logic             Busy
);

    state_t           state, next_state;
    logic [CNT_W-1:0] phase_cnt, pulse_cnt, trig_cnt;
    logic [9:0]       dac_q;
    logic [5:0]       chn_q;
    logic             hit, rise, phase_end, is_wr;
    logic             ctest_d, wr_d, done_d;
    logic [CNT_W-1:0] word;

    trig_edge_sync u_sync (
        .clk   (Clk),
        .rst_n (reset_n),
        .din   (Trigger_In),
        .rise  (rise)
    );

    always_comb begin
        phase_end = 1'b0;
        unique case (state)
            ST_PULSE:  phase_end = phase_cnt == CNT_W'(PULSE_WIDTH - 1);
            ST_WINDOW: phase_end = phase_cnt == CNT_W'(TRIG_WINDOW - 1);
            ST_GAP:    phase_end = phase_cnt == CNT_W'(PULSE_GAP - 1);
            default:   phase_end = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state != ST_IDLE && Test_Abort) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (Single_Test_Start) next_state = ST_PULSE;
                ST_PULSE:
                    if (phase_end) next_state = ST_WINDOW;
                ST_WINDOW:
                    if (phase_end) next_state = ST_GAP;
                ST_GAP:
                    if (phase_end)
                        next_state = (pulse_cnt == CNT_W'(PULSE_NUM))
                                   ? ST_WR0 : ST_PULSE;
                ST_WR0:
                    if (!SCurve_Data_fifo_full) next_state = ST_WR1;
                ST_WR1:
                    if (!SCurve_Data_fifo_full) next_state = ST_WR2;
                ST_WR2:
                    if (!SCurve_Data_fifo_full) next_state = ST_DONE;
                ST_DONE:
                    next_state = ST_IDLE;
                default:
                    next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        word = '0;
        unique case (state)
            ST_WR0:  word = {TAG_DAC, 2'b00, dac_q};
            ST_WR1:  word = {TAG_CHN, 6'b0, chn_q};
            ST_WR2:  word = trig_cnt;
            default: word = '0;
        endcase
        is_wr   = state inside {ST_WR0, ST_WR1, ST_WR2};
        wr_d    = is_wr && !SCurve_Data_fifo_full && !Test_Abort;
        ctest_d = next_state == ST_PULSE;
        done_d  = next_state == ST_DONE;
    end

    // Outputs are flopped from next-state decode so they align with state.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            CTest_Pulse            <= 1'b0;
            SCurve_Data_fifo_wr_en <= 1'b0;
            SCurve_Data_fifo_dout  <= '0;
            Single_Test_Done       <= 1'b0;
        end else begin
            CTest_Pulse            <= ctest_d;
            SCurve_Data_fifo_wr_en <= wr_d;
            if (wr_d) SCurve_Data_fifo_dout <= word;
            Single_Test_Done       <= done_d;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            pulse_cnt <= '0;
            trig_cnt  <= '0;
            hit       <= 1'b0;
            dac_q     <= '0;
            chn_q     <= '0;
        end else begin
            if (phase_end || !(state inside {ST_PULSE, ST_WINDOW, ST_GAP}))
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + CNT_W'(1);
            if (state == ST_IDLE && Single_Test_Start) begin
                dac_q     <= DAC_Code;
                chn_q     <= Test_Chn;
                trig_cnt  <= '0;
                pulse_cnt <= '0;
                hit       <= 1'b0;
            end
            if (state == ST_PULSE && phase_end)
                pulse_cnt <= pulse_cnt + CNT_W'(1);
            // An edge seen in the last window cycle still counts.
            if (state == ST_WINDOW) begin
                if (phase_end) begin
                    hit <= 1'b0;
                    if (hit || rise) trig_cnt <= sat_inc(trig_cnt);
                end else if (rise) begin
                    hit <= 1'b1;
                end
            end
        end
    end

    assign Busy = state != ST_IDLE;

endmodule

// File: tb/tb_scurve_single_point_test.sv
// Directed bench for scurve_single_point_test with PULSE_NUM=4.
module tb_scurve_single_point_test;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Single_Test_Start = 1'b0;
    logic        Test_Abort = 1'b0;
    logic [9:0]  DAC_Code = '0;
    logic [5:0]  Test_Chn = '0;
    logic        Trigger_In = 1'b0;
    logic        CTest_Pulse;
    logic        SCurve_Data_fifo_full = 1'b0;
    logic        SCurve_Data_fifo_wr_en;
    logic [15:0] SCurve_Data_fifo_dout;
    logic        Single_Test_Done;
    logic        Busy;

    always #10 Clk = ~Clk;

    scurve_single_point_test #(
        .PULSE_NUM   (4),
        .PULSE_WIDTH (4),
        .TRIG_WINDOW (16),
        .PULSE_GAP   (64)
    ) dut (
        .Clk                    (Clk),
        .reset_n                (reset_n),
        .Single_Test_Start      (Single_Test_Start),
        .Test_Abort             (Test_Abort),
        .DAC_Code               (DAC_Code),
        .Test_Chn               (Test_Chn),
        .Trigger_In             (Trigger_In),
        .CTest_Pulse            (CTest_Pulse),
        .SCurve_Data_fifo_full  (SCurve_Data_fifo_full),
        .SCurve_Data_fifo_wr_en (SCurve_Data_fifo_wr_en),
        .SCurve_Data_fifo_dout  (SCurve_Data_fifo_dout),
        .Single_Test_Done       (Single_Test_Done),
        .Busy                   (Busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last run.
    int          n_pulse, bad_width, done_cnt, done_at, viol;
    logic        first_ct, busy_post, ct_ev, busy_ev;
    logic [15:0] words[$];

    function automatic logic [15:0] wd(input int i);
        return (i < words.size()) ? words[i] : 16'hxxxx;
    endfunction

    // mode: 1 trig 3 cycles after fall, 2 trig in PULSE/GAP only,
    //       3 three edges per window.
    // ev:   0 none, 1 abort mid 3rd pulse, 2 reset mid 2nd pulse,
    //       3 restart with new DAC in 1st window.
    task automatic run(input logic [9:0] dac, input logic [5:0] chn,
                       input int mode, input int full_len,
                       input int ev, input int budget);
        int   since_fall, since_rise, hi_len, full_left, ev_k;
        logic prev_ct, done_prev, full_prev, seen_wr, fired;
        logic [15:0] last_dout;
        n_pulse = 0; bad_width = 0; done_cnt = 0; done_at = -1;
        viol = 0; busy_post = 1'bx; ct_ev = 1'bx; busy_ev = 1'bx;
        words.delete();
        since_fall = 1000; since_rise = 1000; hi_len = 0;
        full_left = 0; ev_k = -10;
        prev_ct = 0; done_prev = 0; full_prev = 0;
        seen_wr = 0; fired = 0; last_dout = SCurve_Data_fifo_dout;
        @(negedge Clk);
        DAC_Code = dac;
        Test_Chn = chn;
        Single_Test_Start = 1'b1;
        @(negedge Clk);
        first_ct = CTest_Pulse;
        for (int k = 0; k < budget; k++) begin
            if (k > 0) @(negedge Clk);
            Single_Test_Start = 1'b0;
            Test_Abort = 1'b0;
            if (!reset_n) reset_n = 1'b1;
            if (CTest_Pulse && !prev_ct) begin
                n_pulse++; hi_len = 0; since_rise = 0;
            end else if (since_rise < 1000) since_rise++;
            if (!CTest_Pulse && prev_ct) begin
                if (hi_len != 4) bad_width++;
                since_fall = 0;
            end else if (since_fall < 1000) since_fall++;
            if (CTest_Pulse) hi_len++;
            prev_ct = CTest_Pulse;
            if (SCurve_Data_fifo_wr_en) begin
                words.push_back(SCurve_Data_fifo_dout);
                if (full_prev) viol++;
            end
            if (full_prev && SCurve_Data_fifo_dout !== last_dout) viol++;
            last_dout = SCurve_Data_fifo_dout;
            if (Single_Test_Done) begin done_cnt++; done_at = k; end
            if (done_prev) busy_post = Busy;
            done_prev = Single_Test_Done;
            if (k == ev_k + 1) begin ct_ev = CTest_Pulse; busy_ev = Busy; end
            Trigger_In =
                (mode == 1 && (since_fall == 3 || since_fall == 4)) ||
                (mode == 2 && ((CTest_Pulse && since_rise < 2) ||
                               (since_fall >= 30 && since_fall < 32))) ||
                (mode == 3 && (since_fall == 2 || since_fall == 4 ||
                               since_fall == 6));
            if (full_len > 0) begin
                if (full_left > 0) full_left--;
                else if (SCurve_Data_fifo_wr_en && !seen_wr) begin
                    seen_wr = 1; full_left = full_len;
                end
                SCurve_Data_fifo_full = full_left > 0;
            end
            full_prev = SCurve_Data_fifo_full;
            if (!fired && ev == 1 && n_pulse == 3 && hi_len == 2) begin
                fired = 1; Test_Abort = 1'b1; ev_k = k;
            end
            if (!fired && ev == 2 && n_pulse == 2 && hi_len == 1) begin
                fired = 1; reset_n = 1'b0;
                #1;
                ct_ev = CTest_Pulse; busy_ev = Busy;
            end
            if (!fired && ev == 3 && n_pulse == 1 && since_fall == 5) begin
                fired = 1; Single_Test_Start = 1'b1; DAC_Code = 10'd5;
            end
        end
        Trigger_In = 1'b0;
        SCurve_Data_fifo_full = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_ctest", CTest_Pulse, 0);
        chk("rst_wr_en", SCurve_Data_fifo_wr_en, 0);
        chk("rst_dout", SCurve_Data_fifo_dout, 0);
        chk("rst_done", Single_Test_Done, 0);
        chk("rst_busy", Busy, 0);
        reset_n = 1'b1;

        run(10'd300, 6'd16, 1, 0, 0, 360);
        chk("t1_first_ct", first_ct, 1);
        chk("t1_pulses", n_pulse, 4);
        chk("t1_bad_width", bad_width, 0);
        chk("t1_nwords", words.size(), 3);
        chk("t1_w0", wd(0), 16'h112C);
        chk("t1_w1", wd(1), 16'h2010);
        chk("t1_w2", wd(2), 16'h0004);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_at", done_at, 339);
        chk("t1_busy_post", busy_post, 0);

        run(10'd300, 6'd16, 2, 0, 0, 360);
        chk("t2_nwords", words.size(), 3);
        chk("t2_w2", wd(2), 16'h0000);
        chk("t2_done_cnt", done_cnt, 1);

        run(10'd300, 6'd16, 3, 0, 0, 360);
        chk("t3_w2", wd(2), 16'h0004);

        run(10'h3FF, 6'd63, 1, 10, 0, 370);
        chk("t4_viol", viol, 0);
        chk("t4_nwords", words.size(), 3);
        chk("t4_w0", wd(0), 16'h13FF);
        chk("t4_w1", wd(1), 16'h203F);
        chk("t4_w2", wd(2), 16'h0004);
        chk("t4_done_at", done_at, 349);

        run(10'd300, 6'd16, 1, 0, 1, 360);
        chk("t5a_pulses", n_pulse, 3);
        chk("t5a_ct_next", ct_ev, 0);
        chk("t5a_busy_next", busy_ev, 0);
        chk("t5a_nwords", words.size(), 0);
        chk("t5a_done_cnt", done_cnt, 0);

        run(10'd300, 6'd16, 1, 0, 2, 360);
        chk("t5r_ct_now", ct_ev, 0);
        chk("t5r_busy_now", busy_ev, 0);
        chk("t5r_nwords", words.size(), 0);
        chk("t5r_done_cnt", done_cnt, 0);

        run(10'd77, 6'd1, 1, 0, 0, 360);
        chk("t5n_w0", wd(0), 16'h104D);
        chk("t5n_w1", wd(1), 16'h2001);
        chk("t5n_w2", wd(2), 16'h0004);
        chk("t5n_done_at", done_at, 339);

        run(10'd300, 6'd16, 1, 0, 3, 360);
        chk("t6_w0", wd(0), 16'h112C);
        chk("t6_w2", wd(2), 16'h0004);
        chk("t6_done_at", done_at, 339);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scurve_single_point_test.md
Name: scurve_single_point_test

Overview:
- Executes one S-curve point for one DAC code and one channel: fires a fixed number of charge-injection (CTest) pulses and counts at most one Microroc trigger per pulse.
- Writes a 3-word result record into the SCurve data FIFO, then pulses done.
- Slave of the S-curve sweep controller through the Single_Test_Start / Single_Test_Done handshake. The sweep controller later drains the FIFO to USB.

Parameters:
- PULSE_NUM, 1000, CTest pulses per point (1..65535).
- PULSE_WIDTH, 4, CTest high time in Clk cycles (>=1).
- TRIG_WINDOW, 16, cycles after the CTest falling edge in which a trigger is accepted (>=1).
- PULSE_GAP, 64, idle cycles after the window before the next pulse (>=1).

Ports:
- Clk  in  1  system clock, 40 MHz
- reset_n  in  1  asynchronous active-low reset
- Single_Test_Start  in  1  one-cycle start strobe
- Test_Abort  in  1  level; forces return to idle
- DAC_Code  in  10  DAC value under test, latched at start
- Test_Chn  in  6  channel under test, latched at start
- Trigger_In  in  1  asynchronous Microroc trigger
- CTest_Pulse  out  1  charge-injection pulse
- SCurve_Data_fifo_full  in  1  FIFO full flag
- SCurve_Data_fifo_wr_en  out  1  FIFO write strobe
- SCurve_Data_fifo_dout  out  16  FIFO write data
- Single_Test_Done  out  1  one-cycle completion strobe
- Busy  out  1  high from the cycle after start until the done cycle inclusive

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, all counters 0, latched DAC/channel 0. Reset mid-test aborts with no FIFO write and no done.
- Trigger_In goes through a 2-FF synchronizer. A rising edge on the synchronized signal is detected with one extra register.
- FSM states:
  - IDLE: on Single_Test_Start, latch DAC_Code/Test_Chn, clear trig_cnt and pulse_cnt, go to PULSE. Start is ignored in every other state.
  - PULSE: CTest_Pulse=1 for PULSE_WIDTH cycles, then go to WINDOW and increment pulse_cnt.
  - WINDOW: TRIG_WINDOW cycles. The first detected rising edge sets a per-pulse hit flag; further edges in the same window are ignored. On exit: if the flag is set, trig_cnt+1, saturating at 16'hFFFF. Flag is cleared. Go to GAP.
  - GAP: PULSE_GAP cycles. If pulse_cnt==PULSE_NUM go to WR0, else go to PULSE.
  - WR0/WR1/WR2: in each state, wr_en=1 only in a cycle where SCurve_Data_fifo_full=0, then advance one state. While full=1, hold the state with wr_en=0 and the data stable.
    - WR0 data = {4'h1, 2'b00, DAC_Code_latched}
    - WR1 data = {4'h2, 6'b0, Test_Chn_latched}
    - WR2 data = trig_cnt
  - DONE: Single_Test_Done=1 for exactly one cycle, then IDLE.
- Edges outside WINDOW are not counted. An edge in the same cycle as the WINDOW-to-GAP transition belongs to the window only if it is detected in the last WINDOW cycle.
- Latency: start to first CTest rise = 1 cycle. Nominal test length = PULSE_NUM*(PULSE_WIDTH+TRIG_WINDOW+PULSE_GAP) + 3 write cycles + 1 done cycle, plus any full-stall cycles.
- Test_Abort=1 in any non-IDLE state: next cycle IDLE, CTest_Pulse=0, wr_en=0, no done. A partial record is permitted if abort hits mid-write; the sweep controller discards it.
- Output registering:
  - CTest_Pulse, wr_en, dout and Single_Test_Done are registered (glitch-free).
  - dout holds its last value when wr_en=0.

Decomposition:
- Shared package scurve_pkg:
  - FSM state encoding
  - record tag constants TAG_DAC=4'h1 and TAG_CHN=4'h2
  - counter width constant CNT_W=16
- One sub-module, trig_edge_sync: 2-FF synchronizer plus rising-edge detector, reusable by the other trigger-counting blocks.

Test Plan:
1. PULSE_NUM=4, DAC_Code=10'd300, Test_Chn=16, one trigger 3 cycles after each CTest fall -> 4 CTest pulses each 4 cycles high; FIFO receives 16'h112C, 16'h2010, 16'h0004; one done pulse; Busy then low.
2. Same setup, triggers only during PULSE or GAP -> trig_cnt word = 16'h0000; 3 words still written.
3. Three trigger edges inside a single window on every pulse, PULSE_NUM=4 -> count word = 16'h0004 (one hit per pulse).
4. SCurve_Data_fifo_full held high for 10 cycles on entering WR1 -> no wr_en for those 10 cycles; WR1 data held stable; all 3 words written once, in order; done delayed by 10 cycles.
5. Test_Abort after 2 pulses, then reset_n low mid-PULSE on a second run -> no FIFO write and no done in either case; CTest_Pulse=0 on the next edge (abort) or immediately (reset); a new start then runs normally.
6. Single_Test_Start re-asserted during WINDOW with a different DAC_Code -> ignored; record carries the originally latched DAC code.
